// File: rtl/countdown_sequencer.sv
// Loadable 4-bit countdown with pause, restart and a blinking DONE display.
// Feeds the digit and blank inputs of the seven-segment decoder.
module countdown_sequencer #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       blank,
    output logic       running,
    output logic       done
);

    localparam logic [31:0] TICK_RELOAD = 32'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t      state;
    state_t      state_d;
    state_t      restart_state;
    logic [31:0] tick_q;
    logic [31:0] tick_d;
    logic [3:0]  digit_d;
    logic        start_q;
    logic        blank_d;
    logic        done_d;
    logic        sedge;
    logic        tick_active;
    logic        tick;

    assign sedge         = start & ~start_q;
    assign restart_state = (load_value != 4'd0) ? RUN : DONE;

    // The divider only counts while actually running unpaused, or while blinking in DONE.
    assign tick_active = ((state == RUN) && !pause) || (state == DONE);
    assign tick        = tick_active && (tick_q == 32'd0);

    // State and datapath registers.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            digit   <= 4'd0;
            tick_q  <= TICK_RELOAD;
            start_q <= 1'b1;
            blank   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            digit   <= digit_d;
            tick_q  <= tick_d;
            start_q <= start;
            blank   <= blank_d;
            done    <= done_d;
        end
    end

    // Next-state logic: a start edge restarts from any state and outranks pause and tick.
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        if (sedge) begin
            state_d = restart_state;
        end else begin
            unique case (state)
                IDLE:    state_d = IDLE;
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick && (digit == 4'd1)) begin
                        state_d = DONE;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output and datapath logic.
    always_comb begin
        digit_d = digit;
        tick_d  = tick_q;
        blank_d = 1'b0;
        done_d  = 1'b0;
        running = (state == RUN);

        if (sedge) begin
            digit_d = load_value;
            tick_d  = TICK_RELOAD;
        end else begin
            if (tick) begin
                tick_d = TICK_RELOAD;
            end else if (tick_active) begin
                tick_d = tick_q - 32'd1;
            end

            unique case (state)
                IDLE: digit_d = load_value;
                RUN: begin
                    if (tick && (digit != 4'd0)) begin
                        digit_d = digit - 4'd1;
                    end
                end
                PAUSED: digit_d = digit;
                DONE: begin
                    digit_d = 4'd0;
                    blank_d = tick ? ~blank : blank;
                end
                default: digit_d = 4'd0;
            endcase
        end

        // A restart that lands in DONE again counts as a fresh entry.
        done_d = (state_d == DONE) && ((state != DONE) || sedge);
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer with TICK_CYCLES=4: directed stimulus
// queues hand-computed output snapshots, a negedge monitor pops and compares them.
module tb_countdown_sequencer;

    localparam int unsigned TICK = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic [3:0] load_value;
    logic [3:0] digit;
    logic       blank;
    logic       running;
    logic       done;

    always #5 clock = ~clock;

    countdown_sequencer #(.TICK_CYCLES(TICK)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pause      (pause),
        .load_value (load_value),
        .digit      (digit),
        .blank      (blank),
        .running    (running),
        .done       (done)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] digit;
        logic       running;
        logic       blank;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    string      name_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [6:0] prev_snap;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int c, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @cyc %0d: got digit=%0d running=%b blank=%b done=%b, want digit=%0d running=%b blank=%b done=%b",
                     name, c, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
        end
    endtask

    task automatic flag(input string name, input int c, input string why);
        total++;
        bad++;
        $display("FAIL %s @cyc %0d: %s", name, c, why);
    endtask

    // Monitor: any output change must coincide with a queued expectation.
    always @(negedge clock) begin
        logic [6:0] snap;
        exp_t       e;
        string      nm;
        snap = {digit, running, blank, done};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            flag(name_q[0], exp_q[0].cyc, "expected snapshot was never sampled");
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, cyc, snap, {e.digit, e.running, e.blank, e.done});
        end else if (mon_en && (snap !== prev_snap)) begin
            flag("unexpected_change", cyc, $sformatf("outputs went %b -> %b", prev_snap, snap));
        end
        prev_snap <= snap;
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_at(input string name, input int c, input logic [3:0] d,
                             input logic r, input logic b, input logic dn);
        exp_t e;
        e.cyc     = c;
        e.digit   = d;
        e.running = r;
        e.blank   = b;
        e.done    = dn;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // One reset cycle, then release; returns right after the first IDLE edge.
    task automatic do_reset(input logic [3:0] lv, input logic st);
        mon_en     = 1'b0;
        reset_n    = 1'b0;
        start      = st;
        pause      = 1'b0;
        load_value = lv;
        @(posedge clock);
        #1;
        expect_at("reset_state", cyc, 4'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        expect_at("idle_preview_after_reset", cyc, lv, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
    endtask

    initial begin
        int c0;
        int r;
        int c1;
        reset_n    = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        load_value = 4'd0;

        // Plain countdown from 3, then DONE blinking with pause ignored.
        do_reset(4'd3, 1'b0);
        c0    = cyc;
        start = 1'b1;
        expect_at("s1_run_entry",        c0 + 1,  4'd3, 1'b1, 1'b0, 1'b0);
        expect_at("s1_digit2",           c0 + 5,  4'd2, 1'b1, 1'b0, 1'b0);
        expect_at("s1_digit1",           c0 + 9,  4'd1, 1'b1, 1'b0, 1'b0);
        expect_at("s1_done_entry",       c0 + 13, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_at("s1_done_pulse_end",   c0 + 14, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at("s1_blink_on",         c0 + 17, 4'd0, 1'b0, 1'b1, 1'b0);
        expect_at("s1_blink_off_paused", c0 + 21, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at("s1_blink_on_again",   c0 + 25, 4'd0, 1'b0, 1'b1, 1'b0);
        wait_to(c0 + 1);
        start = 1'b0;
        wait_to(c0 + 18);
        pause = 1'b1;
        wait_to(c0 + 23);
        pause = 1'b0;
        wait_to(c0 + 26);

        // Countdown from 5 with pause held for 7 sampled edges after digit reaches 4.
        do_reset(4'd5, 1'b0);
        c0    = cyc;
        start = 1'b1;
        expect_at("s2_run_entry",   c0 + 1,  4'd5, 1'b1, 1'b0, 1'b0);
        expect_at("s2_digit4",      c0 + 5,  4'd4, 1'b1, 1'b0, 1'b0);
        expect_at("s2_paused_hold", c0 + 6,  4'd4, 1'b0, 1'b0, 1'b0);
        expect_at("s2_resumed",     c0 + 13, 4'd4, 1'b1, 1'b0, 1'b0);
        expect_at("s2_digit3",      c0 + 17, 4'd3, 1'b1, 1'b0, 1'b0);
        expect_at("s2_digit2",      c0 + 21, 4'd2, 1'b1, 1'b0, 1'b0);
        expect_at("s2_digit1",      c0 + 25, 4'd1, 1'b1, 1'b0, 1'b0);
        expect_at("s2_done_entry",  c0 + 29, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_at("s2_done_end",    c0 + 30, 4'd0, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 1);
        start = 1'b0;
        wait_to(c0 + 5);
        pause = 1'b1;
        wait_to(c0 + 12);
        pause = 1'b0;
        wait_to(c0 + 31);

        // Load of zero goes straight to DONE; a restart from DONE clears blank.
        do_reset(4'd0, 1'b0);
        c0    = cyc;
        start = 1'b1;
        expect_at("s3_zero_done_entry",  c0 + 1,  4'd0, 1'b0, 1'b0, 1'b1);
        expect_at("s3_zero_done_end",    c0 + 2,  4'd0, 1'b0, 1'b0, 1'b0);
        expect_at("s3_blink_on",         c0 + 5,  4'd0, 1'b0, 1'b1, 1'b0);
        expect_at("s3_restart_from_done", c0 + 7, 4'd2, 1'b1, 1'b0, 1'b0);
        expect_at("s3_digit1",           c0 + 11, 4'd1, 1'b1, 1'b0, 1'b0);
        expect_at("s3_done_entry",       c0 + 15, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_at("s3_done_end",         c0 + 16, 4'd0, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 1);
        start = 1'b0;
        wait_to(c0 + 5);
        load_value = 4'd2;
        wait_to(c0 + 6);
        start = 1'b1;
        wait_to(c0 + 7);
        start = 1'b0;
        wait_to(c0 + 17);

        // Restart mid-run from 9: reloads digit and the tick divider.
        do_reset(4'd9, 1'b0);
        c0    = cyc;
        start = 1'b1;
        expect_at("s4_run_entry",     c0 + 1,  4'd9, 1'b1, 1'b0, 1'b0);
        expect_at("s4_digit8",        c0 + 5,  4'd8, 1'b1, 1'b0, 1'b0);
        expect_at("s4_digit7",        c0 + 9,  4'd7, 1'b1, 1'b0, 1'b0);
        expect_at("s4_digit6",        c0 + 13, 4'd6, 1'b1, 1'b0, 1'b0);
        expect_at("s4_restart_load2", c0 + 15, 4'd2, 1'b1, 1'b0, 1'b0);
        expect_at("s4_digit1_reload", c0 + 19, 4'd1, 1'b1, 1'b0, 1'b0);
        expect_at("s4_done_entry",    c0 + 23, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_at("s4_done_end",      c0 + 24, 4'd0, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 1);
        start = 1'b0;
        wait_to(c0 + 14);
        load_value = 4'd2;
        start      = 1'b1;
        wait_to(c0 + 15);
        start = 1'b0;
        wait_to(c0 + 25);

        // Start held through reset, pause coinciding with a tick, restart beating pause.
        do_reset(4'd3, 1'b1);
        c0 = cyc;
        wait_to(c0 + 3);
        start = 1'b0;
        expect_at("s5_held_start_ignored", c0 + 3, 4'd3, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 4);
        start = 1'b1;
        r     = c0 + 5;
        expect_at("s5_run_after_new_edge", r, 4'd3, 1'b1, 1'b0, 1'b0);
        wait_to(r);
        start = 1'b0;
        wait_to(r + 3);
        pause = 1'b1;
        expect_at("s5_pause_eats_no_tick", r + 4, 4'd3, 1'b0, 1'b0, 1'b0);
        wait_to(r + 5);
        pause = 1'b0;
        expect_at("s5_resume",             r + 6, 4'd3, 1'b1, 1'b0, 1'b0);
        expect_at("s5_tick_after_resume",  r + 7, 4'd2, 1'b1, 1'b0, 1'b0);
        wait_to(r + 8);
        start      = 1'b1;
        pause      = 1'b1;
        load_value = 4'd6;
        expect_at("s5_restart_beats_pause", r + 9,  4'd6, 1'b1, 1'b0, 1'b0);
        expect_at("s5_then_paused",         r + 10, 4'd6, 1'b0, 1'b0, 1'b0);
        wait_to(r + 9);
        start = 1'b0;
        wait_to(r + 10);
        pause = 1'b0;
        expect_at("s5_resume2",  r + 11, 4'd6, 1'b1, 1'b0, 1'b0);
        expect_at("s5_digit5",   r + 15, 4'd5, 1'b1, 1'b0, 1'b0);
        wait_to(r + 16);

        // Reset mid-run with start held; live preview, then a fresh start edge.
        do_reset(4'd4, 1'b1);
        c1 = cyc;
        wait_to(c1 + 1);
        load_value = 4'd7;
        expect_at("s6_preview_follows_load", c1 + 2, 4'd7, 1'b0, 1'b0, 1'b0);
        wait_to(c1 + 2);
        start = 1'b0;
        wait_to(c1 + 3);
        start = 1'b1;
        expect_at("s6_run_entry", c1 + 4, 4'd7, 1'b1, 1'b0, 1'b0);
        expect_at("s6_digit6",    c1 + 8, 4'd6, 1'b1, 1'b0, 1'b0);
        wait_to(c1 + 4);
        start = 1'b0;
        wait_to(c1 + 9);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (exp_q.size() != 0) begin
            flag("drain", cyc, $sformatf("%0d expectations still pending", exp_q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
